// File: rtl/tl_async_a_queue_source.sv
// Write side of the TileLink A-channel async crossing: register memory, Gray write index, handshake sync.
// Define TL_ASYNC_SRC_MEM_RESET_EN to give the memory entries a reset to zero.
module tl_async_a_queue_source #(
  parameter int LOG2_DEPTH  = 0,
  parameter int SYNC_STAGES = 3,
  localparam int DEPTH = 1 << LOG2_DEPTH,
  localparam int IW    = LOG2_DEPTH + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [2:0]          enq_bits_opcode,
  input  logic [8:0]          enq_bits_address,
  input  logic [31:0]         enq_bits_data,
  output logic [3*DEPTH-1:0]  async_mem_opcode,
  output logic [9*DEPTH-1:0]  async_mem_address,
  output logic [32*DEPTH-1:0] async_mem_data,
  output logic [IW-1:0]       async_widx,
  input  logic [IW-1:0]       async_ridx,
  output logic                async_safe_widx_valid,
  input  logic                async_safe_ridx_valid,
  output logic                async_safe_source_reset_n,
  input  logic                async_safe_sink_reset_n
);

  localparam int AW = (LOG2_DEPTH == 0) ? 1 : LOG2_DEPTH;
  localparam logic [IW-1:0] FullMask = IW'(DEPTH | (DEPTH >> 1));

  logic [IW-1:0]          ridxSync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ridxValidSync;
  logic [SYNC_STAGES-1:0] sinkRstNSync;
  logic [IW-1:0]          ridxS;
  logic                   ridxValidS;
  logic                   sinkRstNS;
  logic                   sinkReady;
  logic                   full;
  logic                   fire;
  logic [IW-1:0]          widxBin;
  logic [IW-1:0]          nextBin;
  logic [IW-1:0]          widxGray;
  logic                   widxValid;
  logic                   sinkArmed;
  logic [AW-1:0]          wrAddr;
  logic [2:0]             memOpcode  [DEPTH];
  logic [8:0]             memAddress [DEPTH];
  logic [31:0]            memData    [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) ridxSync[k] <= '0;
      ridxValidSync <= '0;
      sinkRstNSync  <= '0;
    end else begin
      ridxSync[0] <= async_ridx;
      for (int k = 1; k < SYNC_STAGES; k++) ridxSync[k] <= ridxSync[k-1];
      ridxValidSync <= {ridxValidSync[SYNC_STAGES-2:0], async_safe_ridx_valid};
      sinkRstNSync  <= {sinkRstNSync[SYNC_STAGES-2:0], async_safe_sink_reset_n};
    end
  end

  assign ridxS      = ridxSync[SYNC_STAGES-1];
  assign ridxValidS = ridxValidSync[SYNC_STAGES-1];
  assign sinkRstNS  = sinkRstNSync[SYNC_STAGES-1];
  assign sinkReady  = ridxValidS & sinkRstNS;
  assign full       = (widxGray == (ridxS ^ FullMask));
  assign enq_ready  = sinkReady & ~full;
  assign fire       = enq_valid & enq_ready;
  assign nextBin    = widxBin + IW'(1);

  generate
    if (LOG2_DEPTH == 0) begin : gSingle
      assign wrAddr = '0;
    end else begin : gMulti
      assign wrAddr = widxBin[AW-1:0];
    end
  endgenerate

  // The sink-reset synchroniser is still low for a few clocks after our own reset, so
  // widxValid only drops for a sink reset once the sink has been seen alive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      widxBin   <= '0;
      widxGray  <= '0;
      widxValid <= 1'b0;
      sinkArmed <= 1'b0;
    end else begin
      sinkArmed <= sinkArmed | sinkRstNS;
      widxValid <= ~(sinkArmed & ~sinkRstNS);
      if (!sinkRstNS) begin
        widxBin  <= '0;
        widxGray <= '0;
      end else if (fire) begin
        widxBin  <= nextBin;
        widxGray <= nextBin ^ (nextBin >> 1);
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : gMem
`ifdef TL_ASYNC_SRC_MEM_RESET_EN
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          memOpcode[i]  <= '0;
          memAddress[i] <= '0;
          memData[i]    <= '0;
        end else if (!sinkRstNS) begin
          memOpcode[i]  <= '0;
          memAddress[i] <= '0;
          memData[i]    <= '0;
        end else if (fire && wrAddr == AW'(i)) begin
          memOpcode[i]  <= enq_bits_opcode;
          memAddress[i] <= enq_bits_address;
          memData[i]    <= enq_bits_data;
        end
      end
`else
      always_ff @(posedge clock) begin
        if (fire && wrAddr == AW'(i)) begin
          memOpcode[i]  <= enq_bits_opcode;
          memAddress[i] <= enq_bits_address;
          memData[i]    <= enq_bits_data;
        end
      end
`endif
      assign async_mem_opcode[3*i +: 3]   = memOpcode[i];
      assign async_mem_address[9*i +: 9]  = memAddress[i];
      assign async_mem_data[32*i +: 32]   = memData[i];
    end
  endgenerate

  assign async_widx                = widxGray;
  assign async_safe_widx_valid     = widxValid;
  assign async_safe_source_reset_n = reset_n;

endmodule

// File: tb/tb_tl_async_a_queue_source.sv
// Directed bench for tl_async_a_queue_source: one instance at depth 1 and one at depth 4.
// Memory reset checks apply only when TL_ASYNC_SRC_MEM_RESET_EN is defined.
module tb_tl_async_a_queue_source;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        v0, r0, wv0, rv0, srn0, skn0;
  logic [2:0]  op0, mop0;
  logic [8:0]  ad0, mad0;
  logic [31:0] da0, mda0;
  logic [0:0]  widx0, ridx0;

  logic         v2, r2, wv2, rv2, srn2, skn2;
  logic [2:0]   op2;
  logic [8:0]   ad2;
  logic [31:0]  da2;
  logic [11:0]  mop2;
  logic [35:0]  mad2;
  logic [127:0] mda2;
  logic [2:0]   widx2, ridx2;

  int assertCount = 0;
  int failCount   = 0;

  tl_async_a_queue_source #(.LOG2_DEPTH(0), .SYNC_STAGES(3)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(v0), .enq_ready(r0),
    .enq_bits_opcode(op0), .enq_bits_address(ad0), .enq_bits_data(da0),
    .async_mem_opcode(mop0), .async_mem_address(mad0), .async_mem_data(mda0),
    .async_widx(widx0), .async_ridx(ridx0),
    .async_safe_widx_valid(wv0), .async_safe_ridx_valid(rv0),
    .async_safe_source_reset_n(srn0), .async_safe_sink_reset_n(skn0)
  );

  tl_async_a_queue_source #(.LOG2_DEPTH(2), .SYNC_STAGES(3)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(v2), .enq_ready(r2),
    .enq_bits_opcode(op2), .enq_bits_address(ad2), .enq_bits_data(da2),
    .async_mem_opcode(mop2), .async_mem_address(mad2), .async_mem_data(mda2),
    .async_widx(widx2), .async_ridx(ridx2),
    .async_safe_widx_valid(wv2), .async_safe_ridx_valid(rv2),
    .async_safe_source_reset_n(srn2), .async_safe_sink_reset_n(skn2)
  );

  function automatic logic [2:0] gray3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic valid, input logic [2:0] op,
                               input logic [8:0] addr, input logic [31:0] data);
    if (which == 0) begin
      v0 = valid; op0 = op; ad0 = addr; da0 = data;
    end else begin
      v2 = valid; op2 = op; ad2 = addr; da2 = data;
    end
  endtask

  logic [2:0] gray4 [4] = '{3'd1, 3'd3, 3'd2, 3'd6};
  logic [2:0] cnt;

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 1'b0, 3'd0, 9'd0, 32'd0);
    applyStimulus(2, 1'b0, 3'd0, 9'd0, 32'd0);
    ridx0 = '0; rv0 = 1'b1; skn0 = 1'b1;
    ridx2 = '0; rv2 = 1'b1; skn2 = 1'b1;
    tick(); tick();

    checkOutput("rst_widx0", 64'(widx0), 64'd0);
    checkOutput("rst_valid0", 64'(wv0), 64'd0);
    checkOutput("rst_ready0", 64'(r0), 64'd0);
    checkOutput("rst_srcrst0", 64'(srn0), 64'd0);
    checkOutput("rst_widx2", 64'(widx2), 64'd0);
`ifdef TL_ASYNC_SRC_MEM_RESET_EN
    checkOutput("rst_mem0", {mop0, mad0, mda0}, 64'd0);
    checkOutput("rst_mem2_lo", mda2[63:0], 64'd0);
    checkOutput("rst_mem2_hi", mda2[127:64], 64'd0);
`endif

    // Release reset and wait for the sink handshake to cross.
    reset_n = 1'b1;
    #1;
    checkOutput("srcrst_follow", 64'(srn0), 64'd1);
    tick();
    checkOutput("valid_first_clk", 64'(wv0), 64'd1);
    checkOutput("ready_not_yet", 64'(r0), 64'd0);
    tick(); tick();
    checkOutput("t1_ready0", 64'(r0), 64'd1);
    checkOutput("t1_ready2", 64'(r2), 64'd1);
    checkOutput("t1_widx0", 64'(widx0), 64'd0);
    checkOutput("t1_valid2", 64'(wv2), 64'd1);

    // Depth-1 single beat fills the queue.
    applyStimulus(0, 1'b1, 3'd4, 9'h1A4, 32'hDEADBEEF);
    tick();
    applyStimulus(0, 1'b0, 3'd0, 9'd0, 32'd0);
    checkOutput("t2_data", 64'(mda0), 64'hDEADBEEF);
    checkOutput("t2_op", 64'(mop0), 64'd4);
    checkOutput("t2_addr", 64'(mad0), 64'h1A4);
    checkOutput("t2_widx", 64'(widx0), 64'd1);
    checkOutput("t2_full", 64'(r0), 64'd0);
    ridx0 = 1'b1;
    tick(); tick();
    checkOutput("t2_ready_early", 64'(r0), 64'd0);
    tick();
    checkOutput("t2_ready", 64'(r0), 64'd1);

    // Depth-4 fill with the read index held at zero.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, 1'b1, 3'(k), 9'(k), 32'hC0DE0000 + k);
      tick();
      checkOutput($sformatf("t3_widx%0d", k), 64'(widx2), 64'(gray4[k]));
    end
    checkOutput("t3_full", 64'(r2), 64'd0);
    applyStimulus(2, 1'b1, 3'd7, 9'h1FF, 32'hBAD0BAD0);
    tick();
    checkOutput("t3_held_widx", 64'(widx2), 64'd6);
    checkOutput("t3_held_mem", 64'(mda2[31:0]), 64'hC0DE0000);
    applyStimulus(2, 1'b0, 3'd0, 9'd0, 32'd0);
    ridx2 = 3'd1;
    tick(); tick();
    checkOutput("t3_ready_early", 64'(r2), 64'd0);
    tick();
    checkOutput("t3_ready", 64'(r2), 64'd1);

    // Sixteen more beats in groups of four, the sink catching up after each group.
    ridx2 = 3'd6;
    tick(); tick(); tick();
    cnt = 3'd4;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(2, 1'b1, 3'(k), 9'(g * 4 + k), 32'hA0000000 + 32'(g * 16 + k));
        tick();
        cnt = cnt + 3'd1;
        checkOutput($sformatf("t4_widx_g%0d_k%0d", g, k), 64'(widx2), 64'(gray3(cnt)));
      end
      applyStimulus(2, 1'b0, 3'd0, 9'd0, 32'd0);
      checkOutput($sformatf("t4_full_g%0d", g), 64'(r2), 64'd0);
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("t4_data_g%0d_e%0d", g, k), 64'(mda2[32*k +: 32]),
                    64'(32'hA0000000 + 32'(g * 16 + k)));
        checkOutput($sformatf("t4_addr_g%0d_e%0d", g, k), 64'(mad2[9*k +: 9]), 64'(g * 4 + k));
      end
      ridx2 = gray3(cnt);
      tick(); tick(); tick();
      checkOutput($sformatf("t4_ready_g%0d", g), 64'(r2), 64'd1);
    end

    // Sink reset pulse mid-stream.
    applyStimulus(2, 1'b1, 3'd1, 9'd1, 32'h11111111);
    tick();
    applyStimulus(2, 1'b0, 3'd0, 9'd0, 32'd0);
    checkOutput("t5_pre_widx", 64'(widx2), 64'd7);
    skn2 = 1'b0;
    ridx2 = 3'd0;
    tick(); tick();
    skn2 = 1'b1;
    tick();
    checkOutput("t5_ready_drop", 64'(r2), 64'd0);
    tick();
    checkOutput("t5_valid_drop", 64'(wv2), 64'd0);
    checkOutput("t5_widx_clear", 64'(widx2), 64'd0);
    checkOutput("t5_ready_low", 64'(r2), 64'd0);
    tick();
    checkOutput("t5_ready_back", 64'(r2), 64'd1);
    applyStimulus(2, 1'b1, 3'd2, 9'h055, 32'h5A5A0001);
    tick();
    applyStimulus(2, 1'b0, 3'd0, 9'd0, 32'd0);
    checkOutput("t5_valid_back", 64'(wv2), 64'd1);
    checkOutput("t5_widx_resume", 64'(widx2), 64'd1);
    checkOutput("t5_entry0", 64'(mda2[31:0]), 64'h5A5A0001);

    // Local reset mid-operation takes effect without a clock.
    reset_n = 1'b0;
    #1;
    checkOutput("lr_widx2", 64'(widx2), 64'd0);
    checkOutput("lr_valid2", 64'(wv2), 64'd0);
    checkOutput("lr_ready2", 64'(r2), 64'd0);
    checkOutput("lr_srcrst2", 64'(srn2), 64'd0);
    checkOutput("lr_widx0", 64'(widx0), 64'd0);
`ifdef TL_ASYNC_SRC_MEM_RESET_EN
    checkOutput("t6_mem0", {mop0, mad0, mda0}, 64'd0);
    checkOutput("t6_mem2_lo", mda2[63:0], 64'd0);
    checkOutput("t6_mem2_hi", mda2[127:64], 64'd0);
    checkOutput("t6_mop2", 64'(mop2), 64'd0);
`endif
    ridx0 = '0;
    ridx2 = '0;
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    checkOutput("t6_ready0", 64'(r0), 64'd1);
    applyStimulus(0, 1'b1, 3'd4, 9'h1A4, 32'hDEADBEEF);
    tick();
    applyStimulus(0, 1'b0, 3'd0, 9'd0, 32'd0);
    checkOutput("t6_widx0", 64'(widx0), 64'd1);
    checkOutput("t6_full0", 64'(r0), 64'd0);
    checkOutput("t6_data0", 64'(mda0), 64'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
